sound_tone_synth: RTL and testbench

- Consumer end of the sound request interface. Takes the 4-bit tone code and enable level from the sound mux and turns them into audio.
- Produces a glitch-free square wave shaped by a linear attack/sustain/release envelope.
- Presents the result two ways: a 1-bit square output for a piezo/GPIO pin, and a 16-bit signed sample served to the audio codec interface on request.

---
 rtl/sound_tone_synth.sv | 146 ++++++++++++++
 tb/tb_sound_tone_synth.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sound_tone_synth.sv
// Tone synthesizer: plays a square wave for a 4-bit tone code and shapes its amplitude
// with a linear attack/sustain/release envelope. The output is a 1-bit pin and signed codec samples.
module sound_tone_synth #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BASE_HZ     = 110,
  parameter int unsigned ENV_DIV     = 50000,
  parameter int unsigned AMP_STEP    = 1000,
  parameter int unsigned AMP_MAX     = 16000
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [3:0]         freq,
  input  logic               enable_sound,
  input  logic               sample_req,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  output logic               square_out,
  output logic               busy
);

  localparam int unsigned HP1 = CLK_FREQ_HZ / (2 * BASE_HZ);
  localparam int unsigned PW  = (HP1 > 1) ? $clog2(HP1) : 1;
  localparam int unsigned EW  = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam int unsigned AW  = 16;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ATTACK  = 2'd1;
  localparam logic [1:0] SUSTAIN = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]    state, next_state;
  logic [AW-1:0] amp, next_amp;
  logic [3:0]    code, next_code;
  logic [PW-1:0] phase, next_phase;
  logic [EW-1:0] env_cnt, next_env;
  logic          pol, next_pol;

  logic          start, stop, tick;
  logic [3:0]    pending;
  logic [AW:0]   amp_up;
  logic [AW-1:0] amp_inc, amp_dec, level;

  // Half-period reload values (HP[k]-1), constant after elaboration
  logic [PW-1:0] hp_m1 [16];
  assign hp_m1[0] = '0;
  for (genvar k = 1; k < 16; k++) begin : g_hp
    assign hp_m1[k] = PW'(CLK_FREQ_HZ / (2 * k * BASE_HZ) - 1);
  end

  assign start   = enable_sound && (freq != 4'd0);
  assign stop    = !start;
  assign tick    = (env_cnt == EW'(ENV_DIV - 1));
  assign pending = (freq != 4'd0) ? freq : code;
  assign amp_up  = {1'b0, amp} + (AW+1)'(AMP_STEP);
  assign amp_inc = (amp_up >= (AW+1)'(AMP_MAX)) ? AW'(AMP_MAX) : amp_up[AW-1:0];
  assign amp_dec = (amp > AW'(AMP_STEP)) ? (amp - AW'(AMP_STEP)) : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      amp        <= '0;
      code       <= '0;
      phase      <= '0;
      env_cnt    <= '0;
      pol        <= 1'b1;
      busy       <= 1'b0;
      square_out <= 1'b0;
    end else begin
      state      <= next_state;
      amp        <= next_amp;
      code       <= next_code;
      phase      <= next_phase;
      env_cnt    <= next_env;
      pol        <= next_pol;
      busy       <= (next_state != IDLE);
      square_out <= next_pol && (next_state != IDLE);
    end
  end

  // Envelope FSM; phase generator reloads only at half-period boundaries
  always_comb begin
    next_state = state;
    next_amp   = amp;
    next_code  = code;
    next_phase = phase;
    next_env   = env_cnt;
    next_pol   = pol;
    if (state == IDLE) begin
      if (start) begin
        next_state = ATTACK;
        next_code  = freq;
        next_phase = hp_m1[freq];
        next_pol   = 1'b1;
        next_env   = '0;
      end
    end else begin
      next_env = tick ? '0 : env_cnt + EW'(1);
      if (phase == '0) begin
        next_pol   = !pol;
        next_phase = hp_m1[pending];
        next_code  = pending;
      end else begin
        next_phase = phase - PW'(1);
      end
      case (state)
        ATTACK: begin
          if (stop) begin
            next_state = RELEASE;
          end else if (tick) begin
            next_amp = amp_inc;
            if (amp_inc == AW'(AMP_MAX)) next_state = SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (stop) next_state = RELEASE;
        end
        RELEASE: begin
          if (start) begin
            next_state = ATTACK;
          end else if (tick) begin
            next_amp = amp_dec;
            if (amp_dec == '0) begin
              next_state = IDLE;
              next_code  = '0;
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  assign level = (state == IDLE) ? '0 : (pol ? amp : (AW'(0) - amp));

  // Codec sample: captures the level of the request cycle, holds between requests
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= sample_req;
      if (sample_req) sample <= $signed(level);
    end
  end

endmodule

// File: tb/tb_sound_tone_synth.sv
// Directed bench for sound_tone_synth using small parameters (HP[1]=10, HP[2]=5, HP[3]=3, tick every 4).
// Edge t counts clock edges after the first tone is requested; checks sample 1 time unit after an edge.
module tb_sound_tone_synth;
  logic               clk = 1'b0;
  logic               resetN;
  logic [3:0]         freq;
  logic               enable_sound;
  logic               sample_req;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               square_out;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  int t        = 0;

  always #5 clk = ~clk;

  sound_tone_synth #(
    .CLK_FREQ_HZ(1000),
    .BASE_HZ    (50),
    .ENV_DIV    (4),
    .AMP_STEP   (1000),
    .AMP_MAX    (4000)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .freq        (freq),
    .enable_sound(enable_sound),
    .sample_req  (sample_req),
    .sample      (sample),
    .sample_valid(sample_valid),
    .square_out  (square_out),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic wait_to(input int n);
    while (t < n) step();
  endtask

  // Request in the current cycle, check the returned sample one edge later
  task automatic grab(input string tag, input logic [15:0] exp);
    sample_req = 1'b1;
    step();
    sample_req = 1'b0;
    check({tag, "_valid"}, {31'd0, sample_valid}, 32'd1);
    check(tag, {16'd0, sample}, {16'd0, exp});
  endtask

  initial begin
    resetN = 1'b0; freq = 4'd0; enable_sound = 1'b0; sample_req = 1'b0;
    step(); step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sq", {31'd0, square_out}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_sample", {16'd0, sample}, 32'd0);
    resetN = 1'b1;
    step(); step();
    grab("idle_sample", 16'h0000);
    check("idle_busy", {31'd0, busy}, 32'd0);
    step();
    check("valid_single", {31'd0, sample_valid}, 32'd0);

    // Attack on code 1
    t = 0; freq = 4'd1; enable_sound = 1'b1;
    step();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_sq", {31'd0, square_out}, 32'd1);
    wait_to(5);  grab("atk_1000", 16'd1000);
    step();
    check("atk_valid_drop", {31'd0, sample_valid}, 32'd0);
    check("atk_sample_hold", {16'd0, sample}, 32'd1000);
    wait_to(9);  grab("atk_2000", 16'd2000);
    check("sq_high_t10", {31'd0, square_out}, 32'd1);
    step();
    check("sq_low_t11", {31'd0, square_out}, 32'd0);
    wait_to(17); grab("sus_neg", 16'hF060);
    wait_to(21); check("sq_high_t21", {31'd0, square_out}, 32'd1);
    wait_to(22); grab("sus_pos", 16'h0FA0);

    // Frequency change three cycles into a half-period
    freq = 4'd2;
    wait_to(30); check("fchg_old_hp", {31'd0, square_out}, 32'd1);
    step();      check("fchg_edge31", {31'd0, square_out}, 32'd0);
    wait_to(35); check("fchg_low35", {31'd0, square_out}, 32'd0);
    step();      check("fchg_edge36", {31'd0, square_out}, 32'd1);
    wait_to(40); check("fchg_high40", {31'd0, square_out}, 32'd1);
    step();      check("fchg_edge41", {31'd0, square_out}, 32'd0);

    // Release from sustain, then re-trigger at amp 2000
    wait_to(44); enable_sound = 1'b0;
    wait_to(49); check("rel_busy", {31'd0, busy}, 32'd1);
    grab("rel_3000", 16'd3000);
    wait_to(53); enable_sound = 1'b1;
    grab("rel_2000", 16'hF830);
    wait_to(55); check("retrig_sq55", {31'd0, square_out}, 32'd0);
    step();      check("retrig_sq56", {31'd0, square_out}, 32'd1);
    wait_to(57); grab("retrig_3000", 16'd3000);
    wait_to(60); check("retrig_sq60", {31'd0, square_out}, 32'd1);
    step();      check("retrig_sq61", {31'd0, square_out}, 32'd0);
    wait_to(66); grab("retrig_sus", 16'h0FA0);

    // Full release with a frequency change while enable is low
    wait_to(68); enable_sound = 1'b0;
    wait_to(71); freq = 4'd3;
    wait_to(84); check("rel_busy84", {31'd0, busy}, 32'd1);
    grab("rel_1000", 16'd1000);
    check("rel_idle_busy", {31'd0, busy}, 32'd0);
    check("rel_idle_sq", {31'd0, square_out}, 32'd0);
    grab("idle_zero", 16'h0000);
    wait_to(90); check("no_restart", {31'd0, busy}, 32'd0);

    // Enable with code 0 stays idle
    freq = 4'd0; enable_sound = 1'b1;
    wait_to(93);
    check("en_f0_busy", {31'd0, busy}, 32'd0);
    check("en_f0_sq", {31'd0, square_out}, 32'd0);

    // Reset mid-tone aborts immediately
    freq = 4'd1;
    wait_to(94); check("tone2_sq", {31'd0, square_out}, 32'd1);
    wait_to(98); grab("tone2_1000", 16'd1000);
    #2 resetN = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_sq", {31'd0, square_out}, 32'd0);
    check("midrst_sample", {16'd0, sample}, 32'd0);
    check("midrst_valid", {31'd0, sample_valid}, 32'd0);
    freq = 4'd0; enable_sound = 1'b0;
    step();
    resetN = 1'b1;
    step();
    grab("post_rst", 16'h0000);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
